// File: rtl/cpu_pkg.sv
// Shared types and width helpers for the sequencer-to-memory bridge.
// The address field is what remains of a word once the opcode is removed.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    localparam int WORD_W_DEFAULT  = 8;
    localparam int OP_W_DEFAULT    = 3;
    localparam int TMO_CYC_DEFAULT = 15;

    function automatic int addr_width(input int word_w, input int op_w);
        return word_w - op_w;
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Bundle of the sequencer-side and memory-side signals of the bridge.
// slave is the bridge's own view; master is the surrounding sequencer/memory.
interface mem_bridge_if #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
);
    import cpu_pkg::*;

    localparam int ADDR_W = addr_width(WORD_W, OP_W);

    logic              CS;
    logic              R_NW;
    logic [ADDR_W-1:0] mar_addr;
    logic [WORD_W-1:0] mdr_wdata;
    logic [WORD_W-1:0] rdata;
    logic              rdata_valid;
    logic              hold;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  CS, R_NW, mar_addr, mdr_wdata, mem_ack, mem_rdata,
        output rdata, rdata_valid, hold, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output CS, R_NW, mar_addr, mdr_wdata, mem_ack, mem_rdata,
        input  rdata, rdata_valid, hold, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_bridge_tmo_counter.sv
// Counts cycles spent waiting for a memory acknowledge; expired flags the
// last permitted wait cycle so the bridge can abort on that same edge.
module tmo_counter #(
    parameter int TMO_CYC = 15
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == 8'(TMO_CYC - 1));

endmodule

// File: rtl/mem_bridge.sv
// Bridges the sequencer's CS/R_NW access strobe onto a req/ack memory bus,
// stalling the sequencer via hold and aborting accesses that never complete.
module mem_bridge
    import cpu_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEFAULT,
    parameter int OP_W    = OP_W_DEFAULT,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         err_clr,
    output logic         timeout_err,
    mem_bridge_if.slave  bus
);

    localparam int ADDR_W = addr_width(WORD_W, OP_W);

    bridge_state_t     state_reg, state_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [WORD_W-1:0] rdata_reg, rdata_next;
    logic              rdata_valid_reg, rdata_valid_next;
    logic              timeout_err_reg, timeout_err_next;
    logic              err_set;
    logic              hold;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expired;

    tmo_counter #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clock   (clock),
        .n_reset (n_reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // The mem_* registers double as the access latch: they capture the
    // request on the IDLE->REQ edge and recirculate while waiting.
    always_comb begin
        state_next       = state_reg;
        mem_req_next     = 1'b0;
        mem_we_next      = 1'b0;
        mem_addr_next    = '0;
        mem_wdata_next   = '0;
        rdata_next       = rdata_reg;
        rdata_valid_next = 1'b0;
        err_set          = 1'b0;
        hold             = 1'b0;
        tmo_clr          = 1'b0;
        tmo_en           = 1'b0;

        case (state_reg)
            IDLE: begin
                hold = bus.CS;
                if (bus.CS) begin
                    state_next     = REQ;
                    tmo_clr        = 1'b1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = ~bus.R_NW;
                    mem_addr_next  = bus.mar_addr;
                    mem_wdata_next = bus.mdr_wdata;
                end
            end
            REQ: begin
                hold   = 1'b1;
                tmo_en = ~bus.mem_ack;
                if (bus.mem_ack) begin
                    state_next = DONE;
                    if (!mem_we_reg) begin
                        rdata_next       = bus.mem_rdata;
                        rdata_valid_next = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_next = DONE;
                    err_set    = 1'b1;
                    if (!mem_we_reg) begin
                        rdata_next       = '0;
                        rdata_valid_next = 1'b1;
                    end
                end else begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = mem_we_reg;
                    mem_addr_next  = mem_addr_reg;
                    mem_wdata_next = mem_wdata_reg;
                end
            end
            DONE: begin
                // Any CS still high here belongs to the access just finished.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        timeout_err_next = err_set | (timeout_err_reg & ~err_clr);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_req_reg     <= mem_req_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            rdata_reg       <= rdata_next;
            rdata_valid_reg <= rdata_valid_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign bus.hold        = hold;
    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.rdata       = rdata_reg;
    assign bus.rdata_valid = rdata_valid_reg;
    assign timeout_err     = timeout_err_reg;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed vector table, hand-written
// reset/back-to-back sequences, then random accesses against a timing model.
module tb_mem_bridge;

    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int ADDR_W = 5;
    localparam int TMO    = 15;

    logic clock   = 1'b0;
    logic n_reset = 1'b0;
    logic err_clr = 1'b0;
    logic timeout_err;

    mem_bridge_if #(.WORD_W(WORD_W), .OP_W(OP_W)) bus ();

    mem_bridge #(
        .WORD_W  (WORD_W),
        .OP_W    (OP_W),
        .TMO_CYC (TMO)
    ) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .bus         (bus.slave)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int txn     = 0;

    // Rising edges of mem_req, counted independently of the access task.
    logic req_prev  = 1'b0;
    int   req_rises = 0;
    always @(posedge clock) begin
        req_prev <= bus.mem_req;
        if (bus.mem_req && !req_prev) req_rises <= req_rises + 1;
    end

    logic [WORD_W-1:0] model_rdata;
    bit                model_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Drives one sequencer access; ack_at/clr_at are 1-based REQ cycle indices (0 = never).
    task automatic run_access(
        input  bit                rnw,
        input  logic [ADDR_W-1:0] addr,
        input  logic [WORD_W-1:0] wdata,
        input  int                ack_at,
        input  logic [WORD_W-1:0] rd_in,
        input  int                clr_at,
        input  bit                cs_tail,
        input  bit                noise,
        output int                n_req,
        output int                n_hold,
        output int                n_valid,
        output logic [WORD_W-1:0] rd_seen,
        output int                bus_err,
        output bit                done_ok
    );
        n_req = 0; n_hold = 0; n_valid = 0; bus_err = 0; done_ok = 0; rd_seen = '0;
        @(negedge clock);
        bus.CS = 1'b1; bus.R_NW = rnw; bus.mar_addr = addr; bus.mdr_wdata = wdata;
        bus.mem_ack = 1'b0; err_clr = 1'b0;
        #1;
        if (bus.hold) n_hold++;
        for (int c = 0; c < 300 && !done_ok; c++) begin
            @(negedge clock);
            if (bus.rdata_valid) begin n_valid++; rd_seen = bus.rdata; end
            if (bus.hold) n_hold++;
            if (bus.mem_req) begin
                n_req++;
                if (bus.mem_we !== !rnw || bus.mem_addr !== addr || bus.mem_wdata !== wdata) bus_err++;
                bus.mem_ack   = (n_req == ack_at);
                bus.mem_rdata = (n_req == ack_at) ? rd_in : WORD_W'($urandom);
                err_clr       = (n_req == clr_at);
            end else begin
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) bus_err++;
                bus.mem_ack   = noise ? 1'($urandom) : 1'b0;
                bus.mem_rdata = WORD_W'($urandom);
                err_clr       = 1'b0;
                if (n_req > 0) begin
                    done_ok = 1;
                    if (!cs_tail) bus.CS = 1'b0;
                end
            end
        end
        if (done_ok) begin
            @(negedge clock);
            if (bus.rdata_valid) n_valid++;
            if (bus.mem_req) bus_err++;
        end
        if (n_valid == 0) rd_seen = bus.rdata;
        bus.CS = 1'b0; bus.mem_ack = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_and_check(
        input string name,
        input bit rnw, input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] wdata,
        input int ack_at, input logic [WORD_W-1:0] rd_in, input int clr_at,
        input bit cs_tail, input bit noise,
        input int exp_req, input int exp_hold, input int exp_valid,
        input logic [WORD_W-1:0] exp_rdata, input bit exp_err
    );
        int n_req, n_hold, n_valid, bus_err;
        logic [WORD_W-1:0] rd_seen;
        bit done_ok;
        run_access(rnw, addr, wdata, ack_at, rd_in, clr_at, cs_tail, noise,
                   n_req, n_hold, n_valid, rd_seen, bus_err, done_ok);
        $display("txn %0d %s %s addr=%0h ack_at=%0d req=%0d hold=%0d valid=%0d rdata=%0h err=%0b",
                 txn, name, rnw ? "RD" : "WR", addr, ack_at, n_req, n_hold, n_valid, rd_seen, timeout_err);
        txn++;
        check({name, "_done"},  32'(done_ok), 32'd1);
        check({name, "_req"},   32'(n_req),   32'(exp_req));
        check({name, "_hold"},  32'(n_hold),  32'(exp_hold));
        check({name, "_valid"}, 32'(n_valid), 32'(exp_valid));
        check({name, "_rdata"}, 32'(rd_seen), 32'(exp_rdata));
        check({name, "_bus"},   32'(bus_err), 32'd0);
        check({name, "_err"},   32'(timeout_err), 32'(exp_err));
    endtask

    typedef struct {
        bit               rnw;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        int               ack_at;
        logic [WORD_W-1:0] rd_in;
        int               clr_at;
        int               exp_req;
        int               exp_hold;
        int               exp_valid;
        logic [WORD_W-1:0] exp_rdata;
        bit               exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int seen, bad, rises0;

        vecs[0] = '{1'b1, 5'h0A, 8'h00,  1, 8'h3C,  0,  1,  2, 1, 8'h3C, 1'b0};
        vecs[1] = '{1'b0, 5'h1F, 8'hA5,  4, 8'h00,  0,  4,  5, 0, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 5'h03, 8'h00, 15, 8'h77,  0, 15, 16, 1, 8'h77, 1'b0};
        vecs[3] = '{1'b1, 5'h11, 8'h00,  0, 8'h99,  0, 15, 16, 1, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 5'h02, 8'h5A,  0, 8'h00, 15, 15, 16, 0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 5'h04, 8'h00,  2, 8'hC3,  1,  2,  3, 1, 8'hC3, 1'b0};
        vecs[6] = '{1'b0, 5'h07, 8'h12, 16, 8'h00,  0, 15, 16, 0, 8'hC3, 1'b1};

        bus.CS = 1'b0; bus.R_NW = 1'b0; bus.mar_addr = '0; bus.mdr_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state, and hold following CS while in reset.
        #2;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_hold_idle", 32'(bus.hold), 32'd0);
        bus.CS = 1'b1; #1;
        check("rst_hold_cs", 32'(bus.hold), 32'd1);
        bus.CS = 1'b0; #1;
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
                            vecs[i].ack_at, vecs[i].rd_in, vecs[i].clr_at, 1'b0, 1'b0,
                            vecs[i].exp_req, vecs[i].exp_hold, vecs[i].exp_valid,
                            vecs[i].exp_rdata, vecs[i].exp_err);
            model_rdata = vecs[i].exp_rdata;
            model_err   = vecs[i].exp_err;
        end

        // err_clr pulse while idle clears the sticky flag.
        @(negedge clock); err_clr = 1'b1;
        @(negedge clock); err_clr = 1'b0;
        check("err_clr_idle", 32'(timeout_err), 32'd0);
        model_err = 1'b0;

        // Acks outside REQ must not start or complete anything.
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            bus.mem_ack = 1'b1; bus.mem_rdata = WORD_W'($urandom);
            if (bus.mem_req !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.rdata !== model_rdata) bad++;
        end
        @(negedge clock); bus.mem_ack = 1'b0;
        check("stray_ack", 32'(bad), 32'd0);
        $display("txn %0d stray_ack bad=%0d", txn, bad); txn++;

        // Reset asserted in the third REQ cycle abandons the access.
        @(negedge clock);
        bus.CS = 1'b1; bus.R_NW = 1'b1; bus.mar_addr = 5'h09; bus.mem_ack = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen < 3; c++) begin
            @(negedge clock);
            if (bus.mem_req) seen++;
        end
        check("rst_mid_reach", 32'(seen), 32'd3);
        n_reset = 1'b0; #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_hold_cs", 32'(bus.hold), 32'd1);
        bus.CS = 1'b0; #1;
        check("rst_mid_hold", 32'(bus.hold), 32'd0);
        @(negedge clock); n_reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus.mem_req !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.hold !== 1'b0) bad++;
        end
        check("rst_mid_idle", 32'(bad), 32'd0);
        check("rst_mid_err", 32'(timeout_err), 32'd0);
        check("rst_mid_rdata", 32'(bus.rdata), 32'd0);
        $display("txn %0d reset_mid_access bad=%0d", txn, bad); txn++;
        model_rdata = '0; model_err = 1'b0;

        // Back-to-back: CS stays high through DONE, next CS two cycles later.
        rises0 = req_rises;
        apply_and_check("b2b_a", 1'b1, 5'h15, 8'h00, 3, 8'h5E, 0, 1'b1, 1'b0, 3, 4, 1, 8'h5E, 1'b0);
        @(negedge clock);
        apply_and_check("b2b_b", 1'b0, 5'h16, 8'hE1, 2, 8'h00, 0, 1'b0, 1'b0, 2, 3, 0, 8'h5E, 1'b0);
        @(negedge clock);
        check("b2b_req_count", 32'(req_rises - rises0), 32'd2);
        model_rdata = 8'h5E;

        // Random accesses against the access-level timing model.
        for (int i = 0; i < 30; i++) begin
            bit rnw, served, clr_hit;
            int ack_at, clr_at, n;
            logic [ADDR_W-1:0] addr;
            logic [WORD_W-1:0] wdata, rd_in, exp_rd;
            rnw    = 1'($urandom);
            addr   = ADDR_W'($urandom);
            wdata  = WORD_W'($urandom);
            rd_in  = WORD_W'($urandom);
            ack_at = $urandom_range(0, TMO + 2);
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 1) : 0;
            served  = (ack_at >= 1 && ack_at <= TMO);
            n       = served ? ack_at : TMO;
            clr_hit = (clr_at >= 1 && clr_at <= n);
            exp_rd  = rnw ? (served ? rd_in : '0) : model_rdata;
            if (!served) model_err = 1'b1;
            else if (clr_hit) model_err = 1'b0;
            model_rdata = exp_rd;
            apply_and_check($sformatf("rnd%0d", i), rnw, addr, wdata, ack_at, rd_in, clr_at,
                            1'($urandom), 1'b1, n, n + 1, rnw ? 1 : 0, exp_rd, model_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
